// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: restoring sequential unsigned divider, one quotient bit per clock
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   start     - begin a division; only sampled in IDLE
//   dividend  - unsigned numerator, captured with an accepted start
//   divisor   - unsigned denominator, captured with an accepted start
//   quotient  - unsigned quotient, valid with done and held until the next accepted start
//   remainder - unsigned remainder, valid with done and held until the next accepted start
//   busy      - high while iterating (CALC)
//   done      - one-cycle pulse when results are valid
//   div_zero  - the last accepted divisor was zero
module seq_divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    // The partial remainder register doubles as the remainder output; a set
    // top bit of diff is the borrow of the trial subtraction.
    always_comb begin
        shifted = {remainder, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && divisor != '0) begin
                        dvd       <= dividend;
                        dvs       <= divisor;
                        quotient  <= '0;
                        remainder <= '0;
                        cnt       <= '0;
                        div_zero  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end else if (start) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                CALC: begin
                    remainder <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], ~diff[WIDTH]};
                    dvd       <= {dvd[WIDTH-2:0], 1'b0};
                    // Counter holds at its final value so it never wraps.
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: scoreboard bench for the sequential divider
module tb_seq_divider_16bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    seq_divider_16bit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.q  = (b == 0) ? 16'hFFFF : a / b;
        e.r  = (b == 0) ? a : a % b;
        e.dz = (b == 0);
        return e;
    endfunction

    // Drives one operation and waits (bounded) for done; no comparisons here.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int bc, output bit both, output bit ok);
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        lat = 0; bc = 0; both = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bc++;
            if (busy && done) both = 1;
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({quotient, remainder, busy, done, div_zero} !== 35'd0) begin
            failures++;
            $display("FAIL reset_state got q=%h r=%h busy=%b done=%b dz=%b exp all zero",
                     quotient, remainder, busy, done, div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc; bit both, ok; exp_t e;
        do_op(16'd100, 16'd7, lat, bc, both, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout done never seen"); end
        checks++; if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
        checks++; if (bc !== 16) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
        checks++; if (both) begin failures++; $display("FAIL basic_busy_done_overlap got=1 exp=0"); end
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                     quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        dividend = 16'd1; divisor = 16'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got q=%0d r=%0d done=%b exp q=14 r=2 done=0", quotient, remainder, done);
        end
    endtask

    task automatic test_max;
        int lat, bc; bit both, ok; exp_t e;
        logic [15:0] b_list [2];
        b_list[0] = 16'h0001; b_list[1] = 16'hFFFF;
        foreach (b_list[k]) begin
            do_op(16'hFFFF, b_list[k], lat, bc, both, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || quotient !== e.q || remainder !== e.r) begin
                failures++;
                $display("FAIL max_div_%h got ok=%b q=%h r=%h exp q=%h r=%h",
                         b_list[k], ok, quotient, remainder, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat, bc; bit both, ok; exp_t e;
        do_op(16'd5, 16'd0, lat, bc, both, ok);
        e = sb.pop_front();
        checks++; if (!ok || lat !== 1) begin failures++; $display("FAIL dz_latency got ok=%b lat=%0d exp lat=1", ok, lat); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL dz_busy got=%0d exp=0", bc); end
        checks++;
        if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
            failures++;
            $display("FAIL dz_result got q=%h r=%0d dz=%b exp q=%h r=%0d dz=%b",
                     quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        do_op(16'd9, 16'd3, lat, bc, both, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
            failures++;
            $display("FAIL dz_clear got ok=%b q=%0d dz=%b exp q=%0d dz=%b", ok, quotient, div_zero, e.q, e.dz);
        end
    endtask

    task automatic test_small;
        int lat, bc; bit both, ok; exp_t e;
        do_op(16'd3, 16'd10, lat, bc, both, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || lat !== 17 || quotient !== e.q || remainder !== e.r) begin
            failures++;
            $display("FAIL small got ok=%b lat=%0d q=%0d r=%0d exp lat=17 q=%0d r=%0d",
                     ok, lat, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_ignore_start;
        int lat; bit ok; exp_t e;
        sb.push_back(model(16'd200, 16'd9));
        @(negedge clk);
        start = 1'b1; dividend = 16'd200; divisor = 16'd9;
        lat = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            start = (lat == 5);
            if (lat == 5) begin dividend = 16'd1; divisor = 16'd1; end
            if (done) begin ok = 1; break; end
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || lat !== 17 || quotient !== e.q || remainder !== e.r) begin
            failures++;
            $display("FAIL ignore_start got ok=%b lat=%0d q=%0d r=%0d exp lat=17 q=%0d r=%0d",
                     ok, lat, quotient, remainder, e.q, e.r);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ignore_start_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen; bit both, ok; exp_t e;
        sb.push_back(model(16'd1000, 16'd3));
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({quotient, remainder, busy, done, div_zero} !== 35'd0) begin
            failures++;
            $display("FAIL reset_mid_state got q=%0d r=%0d busy=%b done=%b dz=%b exp all zero",
                     quotient, remainder, busy, done, div_zero);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL reset_mid_abandon got=%0d active cycles exp=0", seen); end
        do_op(16'd1000, 16'd3, lat, bc, both, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || quotient !== e.q || remainder !== e.r) begin
            failures++;
            $display("FAIL reset_mid_fresh got ok=%b q=%0d r=%0d exp q=%0d r=%0d", ok, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back;
        bit ok; exp_t e;
        sb.push_back(model(16'd50, 16'd4));
        sb.push_back(model(16'd50, 16'd4));
        @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 16'd4;
        for (int n = 0; n < 2; n++) begin
            ok = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin ok = 1; break; end
            end
            e = sb.pop_front();
            checks++;
            if (!ok || quotient !== e.q || remainder !== e.r) begin
                failures++;
                $display("FAIL b2b_result_%0d got ok=%b q=%0d r=%0d exp q=%0d r=%0d",
                         n, ok, quotient, remainder, e.q, e.r);
            end
            if (n == 0) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle got busy=%b done=%b exp 0 0", busy, done);
                end
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy got=%b exp=1", busy); end
            end
        end
    endtask

    task automatic test_random;
        int lat, bc; bit both, ok; exp_t e;
        logic [15:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = (i == 3) ? 16'd0 : 16'($urandom_range(1, (i < 5) ? 255 : 65535));
            do_op(a, b, lat, bc, both, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || both || quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
                failures++;
                $display("FAIL random_%0d %0d/%0d got ok=%b q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                         i, a, b, ok, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_small();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
